// File: rtl/nx_axi4s_packetiser.sv
// nx_axi4s_packetiser: buffers AXI4-stream beats and releases them only as closed, bounded packets.
// Packets close on TLAST, MAX_BEATS, idle timeout, flush or a full buffer.
module nx_axi4s_packetiser #(
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 8,
    parameter int MAX_BEATS    = 16,
    parameter int IDLE_TIMEOUT = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [DATA_WIDTH-1:0]      ib_axi4s_tdata_i,
    input  logic                       ib_axi4s_tlast_i,
    input  logic                       ib_axi4s_tvalid_i,
    output logic                       ib_axi4s_tready_o,
    input  logic                       flush_i,
    output logic [DATA_WIDTH-1:0]      ob_axi4s_tdata_o,
    output logic                       ob_axi4s_tlast_o,
    output logic                       ob_axi4s_tvalid_o,
    input  logic                       ob_axi4s_tready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [15:0]                pkt_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = $clog2(IDLE_TIMEOUT) + 1;

    logic [DATA_WIDTH:0]   r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_cm_ptr, r_rd_ptr, r_open_cnt;
    logic [IW-1:0]         r_idle_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last, r_vld;
    logic [15:0]           r_pkt;

    logic [PW-1:0] w_level;
    logic [AW-1:0] w_wa, w_wa_prev;
    logic          w_full, w_push, w_open, w_close_push, w_close_idle, w_load;

    assign w_level      = r_wr_ptr - r_rd_ptr;
    assign w_full       = w_level == PW'(DEPTH);
    assign w_push       = ib_axi4s_tvalid_i && !w_full;
    assign w_open       = r_open_cnt != '0;
    assign w_wa         = r_wr_ptr[AW-1:0];
    assign w_wa_prev    = w_wa - AW'(1);
    assign w_close_push = w_push && (ib_axi4s_tlast_i || flush_i ||
                          r_open_cnt == PW'(MAX_BEATS-1) || w_level == PW'(DEPTH-1));
    // Without a push, only an open packet can be closed, by flush or idle timeout.
    assign w_close_idle = !w_push && w_open && (flush_i || r_idle_cnt == IW'(IDLE_TIMEOUT-1));
    assign w_load       = (!r_vld || ob_axi4s_tready_i) && r_rd_ptr != r_cm_ptr;

    // The rewritten entry at wr_ptr-1 is always uncommitted, so it never races the read side.
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[w_wa] <= {w_close_push, ib_axi4s_tdata_i};
        else if (w_close_idle)
            r_mem[w_wa_prev][DATA_WIDTH] <= 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_open_cnt <= '0;
            r_idle_cnt <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_vld      <= 1'b0;
            r_pkt      <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_close_push || w_close_idle)
                r_cm_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_open_cnt <= (w_close_push || w_close_idle) ? '0 : w_push ? r_open_cnt + 1'b1 : r_open_cnt;
            r_idle_cnt <= (w_push || w_close_idle) ? '0 : w_open ? r_idle_cnt + 1'b1 : r_idle_cnt;
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_vld    <= 1'b1;
                r_last   <= r_mem[r_rd_ptr[AW-1:0]][DATA_WIDTH];
                r_data   <= r_mem[r_rd_ptr[AW-1:0]][DATA_WIDTH-1:0];
            end else if (ob_axi4s_tready_i) begin
                r_vld    <= 1'b0;
            end
            if (r_vld && ob_axi4s_tready_i && r_last)
                r_pkt <= r_pkt + 1'b1;
        end
    end

    assign ib_axi4s_tready_o = !w_full;
    assign ob_axi4s_tdata_o  = r_data;
    assign ob_axi4s_tlast_o  = r_last;
    assign ob_axi4s_tvalid_o = r_vld;
    assign level_o           = w_level;
    assign pkt_count_o       = r_pkt;
endmodule

// File: tb/tb_nx_axi4s_packetiser.sv
// tb_nx_axi4s_packetiser: directed bench for the packetiser; instance a uses defaults,
// instance b uses MAX_BEATS=4, both share the same inbound stimulus.
module tb_nx_axi4s_packetiser;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] tdata = '0;
    logic        tlast = 1'b0, tvalid = 1'b0, flush = 1'b0, rdy = 1'b1;
    logic [63:0] a_data, b_data;
    logic        a_last, b_last, a_vld, b_vld, a_trdy, b_trdy;
    logic [3:0]  a_level, b_level;
    logic [15:0] a_pkt, b_pkt;
    logic [64:0] qa[$], qb[$];
    logic [64:0] e;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nx_axi4s_packetiser dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .ib_axi4s_tdata_i(tdata), .ib_axi4s_tlast_i(tlast), .ib_axi4s_tvalid_i(tvalid),
        .ib_axi4s_tready_o(a_trdy), .flush_i(flush),
        .ob_axi4s_tdata_o(a_data), .ob_axi4s_tlast_o(a_last), .ob_axi4s_tvalid_o(a_vld),
        .ob_axi4s_tready_i(rdy), .level_o(a_level), .pkt_count_o(a_pkt)
    );

    nx_axi4s_packetiser #(.MAX_BEATS(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .ib_axi4s_tdata_i(tdata), .ib_axi4s_tlast_i(tlast), .ib_axi4s_tvalid_i(tvalid),
        .ib_axi4s_tready_o(b_trdy), .flush_i(flush),
        .ob_axi4s_tdata_o(b_data), .ob_axi4s_tlast_o(b_last), .ob_axi4s_tvalid_o(b_vld),
        .ob_axi4s_tready_i(rdy), .level_o(b_level), .pkt_count_o(b_pkt)
    );

    always @(posedge clk) begin
        if (a_vld && rdy) qa.push_back({a_last, a_data});
        if (b_vld && rdy) qb.push_back({b_last, b_data});
    end

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [63:0] d, input logic l, input logic f);
        tdata = d; tlast = l; tvalid = 1'b1; flush = f;
        tick();
        tvalid = 1'b0; tlast = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; flush = 1'b0; rdy = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick();
        qa.delete();
        qb.delete();
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_vld", a_vld, 0);
        chk("rst_last", a_last, 0);
        chk("rst_data", a_data, 0);
        chk("rst_level", a_level, 0);
        chk("rst_pkt", a_pkt, 0);
        chk("rst_tready", a_trdy, 1);

        // three-beat packet, latency and ordering
        push(64'hA, 0, 0);
        push(64'hB, 0, 0);
        push(64'hC, 1, 0);
        chk("t1_vld_after_E", a_vld, 0);
        tick();
        chk("t1_vld_E1", a_vld, 1);
        chk("t1_A", {a_last, a_data}, {1'b0, 64'hA});
        tick();
        chk("t1_B", {a_last, a_data}, {1'b0, 64'hB});
        tick();
        chk("t1_C", {a_last, a_data}, {1'b1, 64'hC});
        tick();
        chk("t1_vld_end", a_vld, 0);
        chk("t1_pkt", a_pkt, 1);

        // MAX_BEATS=4 split plus timeout remainder
        do_reset();
        for (int i = 0; i < 10; i++) push(64'h100 + 64'(i), 0, 0);
        tick(32);
        chk("t2_before_to_n", qb.size(), 8);
        chk("t2_before_to_vld", b_vld, 0);
        chk("t2_pkt2", b_pkt, 2);
        chk("t2_level2", b_level, 2);
        tick();
        chk("t2_to_vld", b_vld, 1);
        chk("t2_to_data", b_data, 64'h108);
        tick(5);
        chk("t2_n", qb.size(), 10);
        for (int i = 0; i < 10; i++) begin
            e = {(i == 3 || i == 7 || i == 9) ? 1'b1 : 1'b0, 64'h100 + 64'(i)};
            chk($sformatf("t2_beat%0d", i), qb[i], e);
        end
        chk("t2_pkt3", b_pkt, 3);

        // flush at idle_cnt=5
        do_reset();
        push(64'h11, 0, 0);
        push(64'h22, 0, 0);
        tick(5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("t3_b1", {a_vld, a_last, a_data}, {2'b10, 64'h11});
        tick();
        chk("t3_b2", {a_vld, a_last, a_data}, {2'b11, 64'h22});
        tick(40);
        chk("t3_n", qa.size(), 2);
        chk("t3_pkt", a_pkt, 1);
        chk("t3_vld_idle", a_vld, 0);

        // full buffer with sink stalled
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) push(64'h200 + 64'(i), 0, 0);
        chk("t4_full_tready", a_trdy, 0);
        chk("t4_full_level", a_level, 8);
        tick();
        chk("t4_level7", a_level, 7);
        chk("t4_loaded", {a_vld, a_last, a_data}, {2'b10, 64'h200});
        tick(3);
        chk("t4_stable", {a_vld, a_last, a_data}, {2'b10, 64'h200});
        rdy = 1'b1;
        tick(10);
        chk("t4_n", qa.size(), 8);
        chk("t4_b6", qa[6], {1'b0, 64'h206});
        chk("t4_b7", qa[7], {1'b1, 64'h207});
        chk("t4_pkt", a_pkt, 1);

        // push with tlast in the timeout cycle
        do_reset();
        push(64'h300, 0, 0);
        tick(31);
        push(64'h301, 1, 0);
        tick(4);
        chk("t5_n", qa.size(), 2);
        chk("t5_x", qa[0], {1'b0, 64'h300});
        chk("t5_y", qa[1], {1'b1, 64'h301});
        tick(40);
        chk("t5_single", a_pkt, 1);
        chk("t5_n_after", qa.size(), 2);

        // asynchronous reset mid-drain
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) push(64'h400 + 64'(i), i == 4, 0);
        tick();
        rdy = 1'b1;
        tick();
        chk("t6_draining", a_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", a_vld, 0);
        chk("t6_rst_level", a_level, 0);
        chk("t6_rst_pkt", a_pkt, 0);
        tick();
        rst_n = 1'b1;
        qa.delete();
        tick();
        push(64'h500, 0, 0);
        push(64'h501, 1, 0);
        tick(4);
        chk("t6_n", qa.size(), 2);
        chk("t6_b0", qa[0], {1'b0, 64'h500});
        chk("t6_b1", qa[1], {1'b1, 64'h501});
        chk("t6_pkt", a_pkt, 1);
        chk("t6_level", a_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
